// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug/step controller: state encodings and widths.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_HALT  = 2'b11
  } step_state_e;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned STEP_CNT_W = 16;

  // A burst length of zero still issues one step.
  function automatic logic [7:0] burst_len(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// CPU-side debug bus of the step controller: PC/breakpoint in, enable and status out.
interface cpu_step_ctrl_if
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);

  logic [PC_W-1:0]       pc;
  logic [PC_W-1:0]       bp_addr;
  logic                  bp_en;
  logic                  cpu_en;
  logic                  halted;
  logic [1:0]            state;
  logic [STEP_CNT_W-1:0] step_cnt;

  modport master (
    input  pc, bp_addr, bp_en,
    output cpu_en, halted, state, step_cnt
  );

  modport slave (
    output pc, bp_addr, bp_en,
    input  cpu_en, halted, state, step_cnt
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller issuing one-cycle CPU clock-enable pulses.
// Optional PC breakpoint and HALT state built when CPU_STEP_CTRL_BREAKPOINT_EN is defined.
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned PC_W       = PC_W_DEF
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic [7:0]       burst_n,
  cpu_step_ctrl_if.master  dbg
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  step_state_e           state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  cpu_en_q, cpu_en_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic press;
  logic unused_btn_level;
  logic bp_hit;
  logic pulse_req;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk     (CLK100MHZ),
    .rst     (rst),
    .btn_raw (step_btn),
    .level   (unused_btn_level),
    .press   (press)
  );

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  logic [PC_W-1:0] pc_cmp, bp_cmp;
  assign pc_cmp     = dbg.pc;
  assign bp_cmp     = dbg.bp_addr;
  assign bp_hit     = dbg.bp_en && (pc_cmp == bp_cmp);
  assign dbg.halted = (state_q == ST_HALT);
`else
  logic [PC_W-1:0] unused_pc;
  logic            unused_bp_en;
  assign unused_pc    = dbg.pc ^ dbg.bp_addr;
  assign unused_bp_en = dbg.bp_en;
  assign bp_hit       = 1'b0;
  assign dbg.halted   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    remaining_d = remaining_q;
    cpu_en_d    = 1'b0;
    pulse_req   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run_sw) begin
          state_d = ST_RUN;
          tick_d  = '0;
        end else if (press) begin
          state_d     = ST_BURST;
          remaining_d = burst_len(burst_n);
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_d = ST_IDLE;
        end else if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          pulse_req = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_BURST: begin
        pulse_req   = 1'b1;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q <= 8'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        // Step past the breakpoint: this pulse bypasses the compare.
        if (press) begin
          cpu_en_d = 1'b1;
          tick_d   = '0;
          state_d  = run_sw ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hit overrides whatever transition RUN/BURST chose above.
    if (pulse_req) begin
      if (bp_hit) begin
        state_d     = ST_HALT;
        remaining_d = '0;
      end else begin
        cpu_en_d = 1'b1;
      end
    end

    step_cnt_d = step_cnt_q + STEP_CNT_W'(cpu_en_d);
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      remaining_q <= '0;
      cpu_en_q    <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      remaining_q <= remaining_d;
      cpu_en_q    <= cpu_en_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign dbg.cpu_en   = cpu_en_q;
  assign dbg.state    = state_q;
  assign dbg.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with TICK_DIV=4, DEB_CYCLES=3; reference model tracks every cycle.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  localparam bit BP_BUILT   = 1'b1;
  localparam int BP_P1      = 2;
  localparam int BP_ST1     = 3;
  localparam int BP_P2      = 1;
`else
  localparam bit BP_BUILT   = 1'b0;
  localparam int BP_P1      = 4;
  localparam int BP_ST1     = 1;
  localparam int BP_P2      = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] burst_n = 8'd0;

  cpu_step_ctrl_if #(.PC_W(32)) dbg ();

  cpu_step_ctrl #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB),
    .PC_W       (32)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .burst_n   (burst_n),
    .dbg       (dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int npulse   = 0;
  bit pc_auto  = 1'b0;

  // Reference model: mode codes follow the LED encoding (0 idle,1 run,2 burst,3 halt).
  int          m_st, m_runc, m_left;
  bit          m_level, m_press, m_cpu_en;
  int unsigned m_cnt;
  bit          rawh[$];
  bit          smp[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_runc = 0; m_left = 0;
    m_level = 1'b0; m_press = 1'b0; m_cpu_en = 1'b0; m_cnt = 0;
    rawh.delete(); smp.delete();
  endtask

  // One rising edge with the inputs currently applied.
  task automatic model_step();
    bit want, pulse, s, flip;
    want = 1'b0; pulse = 1'b0;
    case (m_st)
      0: if (run_sw) begin m_st = 1; m_runc = 0; end
         else if (m_press) begin m_st = 2; m_left = (burst_n == 8'd0) ? 1 : int'(burst_n); end
      1: if (!run_sw) m_st = 0;
         else begin m_runc++; if (m_runc % TD == 0) want = 1'b1; end
      2: begin want = 1'b1; m_left--; if (m_left == 0) m_st = 0; end
      default: if (m_press) begin pulse = 1'b1; m_st = run_sw ? 1 : 0; m_runc = 0; end
    endcase
    if (want) begin
      if (BP_BUILT && dbg.bp_en && dbg.pc == dbg.bp_addr) begin m_st = 3; m_left = 0; end
      else pulse = 1'b1;
    end
    m_cpu_en = pulse;
    if (pulse) m_cnt = (m_cnt + 1) % 65536;

    // Accepted level flips once the last DB synchronized samples all disagree with it.
    rawh.push_back(step_btn);
    s = (rawh.size() >= 3) ? rawh[rawh.size()-3] : 1'b0;
    smp.push_back(s);
    flip = (smp.size() >= DB);
    for (int i = 0; i < DB; i++)
      if (flip && smp[smp.size()-1-i] == m_level) flip = 1'b0;
    m_press = flip && !m_level;
    if (flip) m_level = !m_level;
    while (rawh.size() > 4) void'(rawh.pop_front());
    while (smp.size() > DB) void'(smp.pop_front());
  endtask

  function automatic logic [31:0] model_outs();
    logic [19:0] e;
    e = {m_cpu_en, (m_st == 3), 2'(m_st), 16'(m_cnt)};
    return {12'd0, e};
  endfunction

  function automatic logic [31:0] dut_outs();
    return {12'd0, dbg.cpu_en, dbg.halted, dbg.state, dbg.step_cnt};
  endfunction

  task automatic tick();
    model_step();
    @(negedge clk);
    chk("outputs", dut_outs(), model_outs());
    if (dbg.cpu_en) begin
      npulse++;
      if (pc_auto) dbg.pc = dbg.pc + 32'd4;
    end
  endtask

  task automatic press_btn(input int hold);
    if (hold > 0) begin
      step_btn = 1'b1;
      repeat (hold) tick();
      step_btn = 1'b0;
    end
  endtask

  typedef struct {
    bit         run;
    logic [7:0] bn;
    int         hold;
    int         wait_c;
    int         exp_pulses;
    int         exp_state;
  } vec_t;

  vec_t vt[6];
  int   btn_hold;

  initial begin
    vt[0] = '{1'b0, 8'd3, 5, 15, 3, 0};   // burst of 3
    vt[1] = '{1'b0, 8'd0, 5, 15, 1, 0};   // burst_n 0 -> one step
    vt[2] = '{1'b0, 8'd3, 2, 15, 0, 0};   // 2-cycle glitch, no press
    vt[3] = '{1'b0, 8'd6, 5, 20, 6, 0};   // burst of 6
    vt[4] = '{1'b1, 8'd0, 0, 20, 4, 1};   // free run 20 cycles
    vt[5] = '{1'b0, 8'd0, 0, 10, 0, 0};   // run dropped, no more pulses

    dbg.pc = 32'h0040_0000; dbg.bp_addr = 32'h0; dbg.bp_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", dut_outs(), 32'd0);
    repeat (4) tick();

    foreach (vt[i]) begin
      run_sw  = vt[i].run;
      burst_n = vt[i].bn;
      npulse  = 0;
      press_btn(vt[i].hold);
      repeat (vt[i].wait_c) tick();
      chk($sformatf("vec%0d_pulses", i), npulse, vt[i].exp_pulses);
      chk($sformatf("vec%0d_state", i), {30'd0, dbg.state}, vt[i].exp_state);
    end

    // run_sw rises in the same cycle the press is presented
    burst_n = 8'd3;
    step_btn = 1'b1;
    repeat (5) tick();
    run_sw = 1'b1; npulse = 0;
    tick();
    step_btn = 1'b0;
    chk("simul_state", {30'd0, dbg.state}, 32'd1);
    repeat (TD - 1) tick();
    chk("simul_no_burst", npulse, 0);
    tick();
    chk("simul_first_run", npulse, 1);
    run_sw = 1'b0;
    repeat (12) tick();

    // Reset in the middle of a RUN pulse
    run_sw = 1'b1;
    for (int k = 0; k < 20 && !dbg.cpu_en; k++) tick();
    chk("rst_pre_cpu_en", {31'd0, dbg.cpu_en}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", dut_outs(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; run_sw = 1'b0;
    model_reset();
    repeat (4) tick();

    // Breakpoint at 0x00400008 with PC advancing per pulse
    dbg.bp_en = 1'b1; dbg.bp_addr = 32'h0040_0008; dbg.pc = 32'h0040_0000;
    pc_auto = 1'b1; run_sw = 1'b1; npulse = 0;
    repeat (20) tick();
    chk("bp_pulses", npulse, BP_P1);
    chk("bp_state", {30'd0, dbg.state}, BP_ST1);
    npulse = 0;
    press_btn(5);
    repeat (3) tick();
    chk("bp_resume_pulses", npulse, BP_P2);
    chk("bp_resume_state", {30'd0, dbg.state}, 32'd1);
    run_sw = 1'b0; pc_auto = 1'b0; dbg.bp_en = 1'b0;
    repeat (12) tick();

    // Randomized traffic against the model
    btn_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) run_sw = ~run_sw;
      if (btn_hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        btn_hold = $urandom_range(1, 8);
      end else begin
        btn_hold--;
      end
      if ($urandom_range(0, 49) == 0) burst_n = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 5) dbg.pc = 32'h0040_0000 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) dbg.bp_addr = 32'h0040_0000 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) dbg.bp_en = ~dbg.bp_en;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Run/step controller for the board-level MIPS core. Sits between the 100 MHz board clock domain and the CPU, and issues one-cycle clock-enable pulses to the core. Modes: free-run at a divided rate, single-step or N-step bursts from a debounced push-button, and an optional PC breakpoint that halts execution. Replaces gating the CPU clock with a switch, so the whole design stays on one clock.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: clock cycles between run-mode steps (1 Hz).
- `DEB_CYCLES`, 1_000_000: cycles the synchronized button must be stable before a level is accepted (10 ms).
- `PC_W`, 32: PC / breakpoint width.

Ports:
- `CLK100MHZ` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run_sw` in 1: 1 = free-run, 0 = step mode. A synchronous level.
- `step_btn` in 1: raw asynchronous push-button.
- `burst_n` in 8: steps per press in step mode. The value 0 is treated as 1.
- `pc` in PC_W: current CPU PC.
- `bp_addr` in PC_W: breakpoint address.
- `bp_en` in 1: breakpoint enable.
- `cpu_en` out 1: registered enable pulse. The CPU commits one instruction per high cycle.
- `halted` out 1: high while in HALT.
- `state` out 2: FSM state, for the LEDs.
- `step_cnt` out 16: number of pulses issued. Wraps 0xFFFF→0.

## Operation
- **Button path:** 2-flop synchronizer, then a stability counter. The accepted level changes after DEB_CYCLES consecutive equal samples. A `press` is a one-cycle pulse on the accepted 0→1 edge.
- **FSM states** (encoding):
  - IDLE=00
  - RUN=01
  - BURST=10
  - HALT=11
- **IDLE:**
  - `run_sw`=1 → RUN. The tick counter is cleared.
  - Otherwise, `press` → BURST. `remaining` loads max(`burst_n`,1).
  - If both occur in the same cycle, RUN wins and the press is dropped.
- **RUN:**
  - The tick counter counts 0..TICK_DIV-1. At terminal count it wraps and a pulse is requested.
  - `run_sw`=0 → IDLE next cycle. No pulse is issued in that cycle.
  - `press` is ignored.
- **BURST:**
  - Requests a pulse every cycle and decrements `remaining`.
  - After the pulse with `remaining`=1, goes to IDLE.
  - `run_sw` and `press` are ignored until the burst ends.
- **Breakpoint hit:** `bp_en` && `pc`==`bp_addr` in a cycle where RUN/BURST requests a pulse. The pulse is suppressed, the state goes to HALT, and `remaining` is discarded.
- **HALT:**
  - `cpu_en`=0 and `halted`=1.
  - `press` issues exactly one pulse, with the breakpoint check bypassed so the CPU can step past the breakpoint.
  - The next state is then RUN if `run_sw`=1, else IDLE.
- **`step_cnt`:** +1 for every cycle `cpu_en` is asserted.

## Timing
- **Reset values:**
  - `state`=IDLE, `cpu_en`=0, `halted`=0, `step_cnt`=0.
  - The tick counter, `remaining` and the debounce counter are 0.
  - The accepted button level is 0.
- **Pulse latency:** `cpu_en` rises in the cycle after the request (registered output).
- **Breakpoint compare:** uses `pc` in the request cycle. The CPU is frozen while `cpu_en`=0, so `pc` is stable.
- **RUN:** the first pulse comes TICK_DIV cycles after entering RUN, then one pulse every TICK_DIV cycles.
- **BURST N:** the first pulse comes 1 cycle after entering BURST. Pulses then appear on N consecutive cycles.
- **Button latency:** `press` occurs DEB_CYCLES+2 cycles after the raw edge settles. Bounces shorter than DEB_CYCLES produce no press.
- **Reset mid-operation:** aborts immediately. An in-flight `cpu_en` drops asynchronously.

## Configuration
- **`CPU_STEP_CTRL_BREAKPOINT_EN` defined:** the breakpoint compare and HALT state are built as described above.
- **Not defined:**
  - `bp_addr`, `bp_en` and `pc` are unused.
  - HALT is unreachable.
  - `halted` is tied to 0.
  - `state` never reads 11.

## Structure
- **Shared package `cpu_dbg_pkg`:** state encodings (IDLE/RUN/BURST/HALT), `PC_W` default, and the `step_cnt` width.
- **Sub-module `btn_debounce`:** synchronizer, stability counter and rising-edge pulse. Parameter DEB_CYCLES. Reusable for other board buttons.

## Test plan
All tests use TICK_DIV=4 and DEB_CYCLES=3.
- **Reset:** assert `rst` mid-RUN → outputs go to their reset values immediately and `step_cnt`=0.
- **Run:** `run_sw`=1 for 20 cycles → `cpu_en` pulses at cycles 4, 8, 12, 16 after entry and `step_cnt`=4. Dropping `run_sw` → no further pulses.
- **Burst:**
  - `burst_n`=3 with a clean press → exactly 3 consecutive `cpu_en` cycles, then IDLE.
  - `burst_n`=0 → exactly 1 pulse.
- **Debounce:** a 2-cycle glitch on `step_btn` → no press. A 5-cycle stable high → exactly one press.
- **Breakpoint:**
  - `bp_addr`=0x0040_0008, `pc` advanced by the testbench +4 per pulse from 0x0040_0000, RUN → 2 pulses, then HALT with `halted`=1.
  - A press in HALT → one pulse, then RUN resumes.
- **Simultaneous:** `run_sw` rises in the same cycle as a press in IDLE → RUN entered and no burst pulses.
